// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NUM_REQ producers.
// Supports bursts held until the last beat, capped at MAX_BURST beats per tenure.
module fifo_push_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    localparam int unsigned IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_grant_o,
    output logic                          push_valid_o,
    output logic [DATA_WIDTH-1:0]         push_data_o,
    input  logic                          push_grant_i,
    output logic [IDX_W-1:0]              owner_o,
    output logic                          locked_o
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   beat_q, beat_d;

    logic [IDX_W-1:0]   sel;
    logic               sel_valid;
    logic               xfer;
    logic               release_burst;

    // Selection: owner while locked, else first valid requester from rr_q with modulo wrap
    always_comb begin
        int unsigned idx;
        logic        found;
        sel   = rr_q;
        found = 1'b0;
        idx   = 0;
        if (state_q == LOCKED) begin
            sel = owner_q;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = 32'(rr_q) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!found && req_valid_i[IDX_W'(idx)]) begin
                    found = 1'b1;
                    sel   = IDX_W'(idx);
                end
            end
        end
    end

    assign sel_valid     = req_valid_i[sel];
    assign xfer          = reset_n & sel_valid & push_grant_i;
    assign release_burst = req_last_i[sel] | ((32'(beat_q) + 32'd1) == MAX_BURST);

    // Push-port outputs; forced to zero while reset is asserted
    always_comb begin
        push_valid_o = reset_n & sel_valid;
        push_data_o  = '0;
        req_grant_o  = '0;
        owner_o      = reset_n ? sel : '0;
        locked_o     = reset_n & (state_q == LOCKED);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == IDX_W'(i)) begin
                if (reset_n) push_data_o = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                req_grant_o[i] = reset_n & push_grant_i
                               & ((state_q == LOCKED) | req_valid_i[i]);
            end
        end
    end

    // Next-state: lock, release or hold depending on the transfer this cycle
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        if (xfer) begin
            if (release_burst) begin
                state_d = IDLE;
                rr_d    = (32'(sel) + 32'd1 >= NUM_REQ) ? '0 : sel + IDX_W'(1);
                beat_d  = '0;
            end else begin
                state_d = LOCKED;
                owner_d = sel;
                beat_d  = beat_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

endmodule
